secure_reg_access_ctrl: RTL
===========================

// Module: secure_reg_access_ctrl
// PURPOSE
//  Arbitrates and sequences access from NUM_REQ requesters to one secure register (write enable, access enable, thread ID ports).
//  Only thread PRIV_TID may touch the register. All other accesses are denied, counted and reported.
//  After LOCK_THRESH denials, a sticky lockdown denies every access until reset.
//  Sits between bus-side thread agents and the secure register instance.
// PARAMETERS
//  NUM_REQ      4   number of requesters (>=2)
//  DATA_WIDTH   32  register data width
//  TID_WIDTH    3   thread ID width
//  PRIV_TID     0   the only thread ID permitted access
//  CNT_WIDTH    8   violation counter width
//  LOCK_THRESH  16  violation count that sets lockdown (1..2^CNT_WIDTH-1)
// PORTS
//  clk            in   1                   clock, rising edge
//  rst            in   1                   synchronous reset, active-high
//  req            in   NUM_REQ             per-requester request, held until gnt
//  req_wr         in   NUM_REQ             1=write, 0=read
//  req_tid        in   NUM_REQ*TID_WIDTH   thread ID per requester, packed, requester 0 in LSBs
//  req_wdata      in   NUM_REQ*DATA_WIDTH  write data per requester, packed
//  gnt            out  NUM_REQ             one-hot completion pulse
//  rsp_valid      out  1                   response valid; pulses with gnt
//  rsp_err        out  1                   access denied (valid with rsp_valid)
//  rsp_rdata      out  DATA_WIDTH          read data (0 on error or write)
//  reg_access_en  out  1                   secure register access enable
//  reg_wr_en      out  1                   secure register write enable
//  reg_thread_id  out  TID_WIDTH           thread ID presented to the register
//  reg_data_in    out  DATA_WIDTH          write data to the register
//  reg_data_out   in   DATA_WIDTH          register read data, valid 1 cycle after access_en
//  viol_count     out  CNT_WIDTH           saturating count of denied accesses
//  lockdown       out  1                   sticky lockdown flag
// BEHAVIOUR
//  Reset: state=IDLE; ptr=NUM_REQ-1 (requester 0 wins first); every output 0, including viol_count and lockdown.
//  Reset has priority over everything. Reset mid-transaction aborts it: no gnt, no rsp_valid.
//  FSM IDLE->ISSUE->WAIT->RESP->IDLE (allowed); IDLE->ISSUE->RESP->IDLE (denied).
//  IDLE (cycle T): if |req, round-robin pick starting at ptr+1 (wrapping). Latch idx, wr, tid, wdata. ptr<=idx.
//  ISSUE (T+1): allowed = (tid==PRIV_TID) && !lockdown.
//   Allowed: reg_access_en=1, reg_wr_en=wr, reg_thread_id=tid, reg_data_in=wdata for exactly this cycle. Next state WAIT.
//   Denied: reg_access_en=reg_wr_en=0, viol_count+1 (saturates at all-ones). Next state RESP.
//  WAIT (T+2): capture reg_data_out if read; reg_* enables 0.
//  RESP: gnt[idx]=1, rsp_valid=1, rsp_err=!allowed for exactly 1 cycle. Back to IDLE.
//   Allowed read = 4 cycles from req; denied = 3 cycles.
//  rsp_rdata holds its value until the next RESP.
//  reg_thread_id/reg_data_in are 0 whenever reg_access_en=0, so no value leaks.
//  lockdown<=1 in the cycle viol_count reaches LOCK_THRESH; it is cleared only by rst.
//  Requests arriving outside IDLE wait. A req dropped mid-flight still completes (gnt pulses regardless).
//  req/tid/wdata are sampled only in IDLE; changes afterwards are ignored.
//  Back-to-back: the next arbitration happens in the IDLE cycle after RESP (1 bubble).
// STRUCTURE
//  Package secure_reg_pkg: state enum {IDLE,ISSUE,WAIT,RESP} and a PRIV_TID_DEFAULT constant.
//  Sub-module rr_arbiter #(N): inputs req, ptr; outputs one-hot grant + index; purely combinational.
//  Top level: FSM, latches, violation counter, lockdown flop.
// TESTING
//  1 req[0], tid=0, wr=1, wdata=0xDEADBEEF -> access_en+wr_en 1 cycle at T+1, gnt=0001 at T+3, rsp_err=0.
//  2 req[0] read after test 1 -> rsp_rdata=0xDEADBEEF, gnt at T+3; no wr_en.
//  3 req[2] tid=5 write -> no access_en ever; gnt=0100 at T+2, rsp_err=1, viol_count 0->1.
//  4 req=1111 held, all tid=0 -> gnt order 0,1,2,3,0 with 1 idle bubble between transactions.
//  5 16 denied accesses -> lockdown=1; then tid=0 read -> rsp_err=1, no access_en; rst clears both.
//  6 rst asserted during WAIT -> next cycle all outputs 0, no gnt; CNT_WIDTH=2 with 5 denials -> viol_count stays 3.

Source files
------------

// File: rtl/secure_reg_pkg.sv
// Shared types and constants for the secure register access controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package secure_reg_pkg;

    // Transaction sequencer states; denied accesses skip WAIT.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // The thread ID that owns the secure register unless overridden.
    localparam int PRIV_TID_DEFAULT = 0;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among N requesters, starting one past the last winner.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arbiter
    import secure_reg_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;
    logic          found;

    // Walk ptr+1 .. ptr+N (wrapping) and take the first active request.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/secure_reg_access_ctrl.sv
// Serialises requester accesses to one secure register; only PRIV_TID gets through.
// Latency: allowed access responds 3 cycles after the arbitration cycle, denied 2.
// Backpressure: requesters hold req until their gnt pulse; one transaction in flight.
module secure_reg_access_ctrl
    import secure_reg_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int TID_WIDTH   = 3,
    parameter int PRIV_TID    = PRIV_TID_DEFAULT,
    parameter int CNT_WIDTH   = 8,
    parameter int LOCK_THRESH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_wr,
    input  logic [NUM_REQ*TID_WIDTH-1:0]    req_tid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              gnt,
    output logic                            rsp_valid,
    output logic                            rsp_err,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            reg_access_en,
    output logic                            reg_wr_en,
    output logic [TID_WIDTH-1:0]            reg_thread_id,
    output logic [DATA_WIDTH-1:0]           reg_data_in,
    input  logic [DATA_WIDTH-1:0]           reg_data_out,
    output logic [CNT_WIDTH-1:0]            viol_count,
    output logic                            lockdown
);

    localparam int                   IW       = idx_width(NUM_REQ);
    localparam logic [CNT_WIDTH-1:0] LOCK_VAL = CNT_WIDTH'(LOCK_THRESH);
    localparam logic [TID_WIDTH-1:0] PRIV_VAL = TID_WIDTH'(PRIV_TID);

    // Everything sampled from the winning requester in the arbitration cycle.
    typedef struct packed {
        logic [IW-1:0]         idx;
        logic                  wr;
        logic [TID_WIDTH-1:0]  tid;
        logic [DATA_WIDTH-1:0] wdata;
    } txn_t;

    logic [TID_WIDTH-1:0]  tid_a   [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];

    state_t               state_q;
    state_t               state_d;
    txn_t                 txn_q;
    logic [IW-1:0]        ptr_q;
    logic                 err_q;
    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IW-1:0]        arb_idx;
    logic                 arb_vld;
    logic                 allowed;
    logic [CNT_WIDTH-1:0] viol_next;

    genvar g;
    for (g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign tid_a[g]   = req_tid[g*TID_WIDTH +: TID_WIDTH];
        assign wdata_a[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign arb_vld   = |arb_gnt;
    // Lockdown is checked against the live flag so a lock taken by the
    // previous transaction already blocks this one.
    assign allowed   = (txn_q.tid == PRIV_VAL) && !lockdown;
    assign viol_next = (viol_count == '1) ? viol_count : viol_count + 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and all handshake/register-port outputs; register ports are
    // zero outside an allowed ISSUE cycle so no thread ID or data leaks.
    always_comb begin
        state_d       = state_q;
        gnt           = '0;
        rsp_valid     = 1'b0;
        rsp_err       = 1'b0;
        reg_access_en = 1'b0;
        reg_wr_en     = 1'b0;
        reg_thread_id = '0;
        reg_data_in   = '0;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (allowed) begin
                    reg_access_en = 1'b1;
                    reg_wr_en     = txn_q.wr;
                    reg_thread_id = txn_q.tid;
                    reg_data_in   = txn_q.wdata;
                    state_d       = WAIT;
                end else begin
                    state_d = RESP;
                end
            end
            WAIT: begin
                state_d = RESP;
            end
            RESP: begin
                gnt       = {{(NUM_REQ-1){1'b0}}, 1'b1} << txn_q.idx;
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch the winner in IDLE; later changes on the request ports are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            txn_q <= '0;
            ptr_q <= IW'(NUM_REQ - 1);
        end else if (state_q == IDLE && arb_vld) begin
            txn_q.idx   <= arb_idx;
            txn_q.wr    <= req_wr[arb_idx];
            txn_q.tid   <= tid_a[arb_idx];
            txn_q.wdata <= wdata_a[arb_idx];
            ptr_q       <= arb_idx;
        end
    end

    // Response status and read data, settled just before RESP and held after.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= 1'b0;
            rsp_rdata <= '0;
        end else if (state_q == ISSUE) begin
            err_q <= !allowed;
            if (!allowed) begin
                rsp_rdata <= '0;
            end
        end else if (state_q == WAIT) begin
            rsp_rdata <= txn_q.wr ? '0 : reg_data_out;
        end
    end

    // Saturating violation counter and sticky lockdown, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            viol_count <= '0;
            lockdown   <= 1'b0;
        end else if (state_q == ISSUE && !allowed) begin
            viol_count <= viol_next;
            if (viol_next == LOCK_VAL) begin
                lockdown <= 1'b1;
            end
        end
    end

endmodule
